// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   clog2       : ceiling log2 helper
//   pcla_ng     : number of GROUP-bit lookahead slices in a WIDTH-bit word
//   pcla_gps    : slices evaluated per pipeline stage
//   pcla_stage_t: inter-stage payload (low sum, remaining A/B, carry, sub, signs)
// The payload vectors are sized to PCLA_MAX_W so one type serves every
// WIDTH; unused upper bits stay zero and are pruned by synthesis.
package pipelined_cla_pkg;

    localparam int PCLA_MAX_W = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int pcla_ng(input int w, input int g);
        return w / g;
    endfunction

    function automatic int pcla_gps(input int w, input int g, input int s);
        return (w / g) / s;
    endfunction

    typedef struct packed {
        logic [PCLA_MAX_W-1:0] sum_lo;  // sum bits already produced, in place
        logic [PCLA_MAX_W-1:0] a_hi;    // A bits not yet added, right-aligned
        logic [PCLA_MAX_W-1:0] b_hi;    // (possibly inverted) B bits, right-aligned
        logic                  carry;   // carry into the next unprocessed slice
        logic                  sub;     // operation is a subtract
        logic                  sa;      // sign of A
        logic                  sb;      // sign of effective B
    } pcla_stage_t;

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of the top bit
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry into bit n in flattened lookahead form:
    // g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]cin
    function automatic logic la_carry(input logic [GROUP-1:0] gg,
                                      input logic [GROUP-1:0] pp,
                                      input logic ci, input int n);
        logic res;
        logic prod;
        res  = 1'b0;
        prod = 1'b1;
        for (int j = n - 1; j >= 0; j--) begin
            res  = res | (prod & gg[j]);
            prod = prod & pp[j];
        end
        return res | (prod & ci);
    endfunction

    for (genvar i = 0; i <= GROUP; i++) begin : g_carry
        assign c[i] = la_carry(g, p, cin, i);
    end

    assign sum  = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor split into GROUP-bit
// lookahead slices spread over STAGES register stages, with valid/ready
// handshakes and a bubble-collapsing pipeline.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake
//   in_a, in_b, in_cin    : operands and carry-in (cin ignored for subtract)
//   in_sub                : 1 selects A + ~B + 1
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : result and unsigned carry-out (1 = no borrow)
//   out_ovf               : signed overflow
// Optional feature macro: PIPELINED_CLA_SAT_EN saturates out_sum on overflow.
module pipelined_cla_adder
    import pipelined_cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NG   = pcla_ng(WIDTH, GROUP);
    localparam int GPS  = pcla_gps(WIDTH, GROUP, STAGES);
    localparam int SW   = GPS * GROUP;   // bits handled per stage
    localparam int LAST = STAGES - 1;

    if (WIDTH % GROUP != 0) begin : g_bad_group
        $error("WIDTH must be a multiple of GROUP");
    end
    if (NG % STAGES != 0) begin : g_bad_stages
        $error("STAGES must divide WIDTH/GROUP");
    end
    if (WIDTH > PCLA_MAX_W) begin : g_bad_width
        $error("WIDTH exceeds PCLA_MAX_W");
    end

    // ---------------- handshake ----------------
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // Resolved from the output backwards so a full pipe still moves when
    // the downstream accepts.
    always_comb begin
        adv       = '0;
        adv[LAST] = vld_q[LAST] & out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & (!vld_q[k+1] | adv[k+1]);
        end
    end

    assign in_ready = !vld_q[0] | adv[0];

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int k = 1; k <= LAST; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= load | (vld_q & ~adv);
    end

    // ---------------- datapath ----------------
    logic [WIDTH-1:0] b_x;
    pcla_stage_t      in_p;
    pcla_stage_t      cur [STAGES];
    pcla_stage_t      nxt [STAGES];

    assign b_x = in_b ^ {WIDTH{in_sub}};

    always_comb begin
        in_p       = '0;
        in_p.a_hi  = PCLA_MAX_W'(in_a);
        in_p.b_hi  = PCLA_MAX_W'(b_x);
        in_p.carry = in_sub | in_cin;
        in_p.sub   = in_sub;
        in_p.sa    = in_a[WIDTH-1];
        in_p.sb    = b_x[WIDTH-1];
    end

    assign cur[0] = in_p;

    // Deposit this stage's sum bits and shift the consumed operand bits out.
    function automatic pcla_stage_t advance_stage(input pcla_stage_t c_in,
                                                  input logic [SW-1:0] s,
                                                  input logic co, input int k);
        pcla_stage_t r;
        r        = c_in;
        r.sum_lo = c_in.sum_lo | (PCLA_MAX_W'(s) << (k * SW));
        r.a_hi   = c_in.a_hi >> SW;
        r.b_hi   = c_in.b_hi >> SW;
        r.carry  = co;
        return r;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GPS:0]  c;
        logic [SW-1:0] s;

        assign c[0] = cur[k].carry;

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a    (cur[k].a_hi[j*GROUP +: GROUP]),
                .b    (cur[k].b_hi[j*GROUP +: GROUP]),
                .cin  (c[j]),
                .sum  (s[j*GROUP +: GROUP]),
                .cout (c[j+1])
            );
        end

        assign nxt[k] = advance_stage(cur[k], s, c[GPS], k);

        if (k < LAST) begin : g_reg
            pcla_stage_t st_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       st_q <= '0;
                else if (load[k]) st_q <= nxt[k];
            end
            assign cur[k+1] = st_q;
        end
    end

    // ---------------- final stage ----------------
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             unused_last;

    assign res_raw = nxt[LAST].sum_lo[WIDTH-1:0];
    assign cout_d  = nxt[LAST].carry;
    assign ovf_d   = (nxt[LAST].sa == nxt[LAST].sb) & (res_raw[WIDTH-1] != nxt[LAST].sa);

`ifdef PIPELINED_CLA_SAT_EN
    // Overflow direction follows the common operand sign.
    assign sum_d = ovf_d ? {nxt[LAST].sa, {(WIDTH-1){!nxt[LAST].sa}}} : res_raw;
`else
    assign sum_d = res_raw;
`endif

    // Leftover payload fields past the last slice carry no information.
    assign unused_last = ^nxt[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load[LAST]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int ST = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks;
    int   failures;

    logic        rdy_mode;
    logic        rdy_force;
    logic [15:0] pat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
`ifdef PIPELINED_CLA_SAT_EN
        if (e.ovf) e.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    // out_ready driver: fixed value or a pseudo-random pattern, updated
    // shortly after each rising edge.
    initial begin
        int pidx;
        pidx      = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode) begin
                out_ready = pat[pidx];
                pidx      = (pidx + 1) % 16;
            end else begin
                out_ready = rdy_force;
            end
        end
    end

    // Monitor: compares every presented result with the scoreboard head,
    // and checks in_ready against the bench's occupancy count.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !((sbq.size() == ST) && !out_ready));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stale: unexpected result sum=%0h", out_sum);
                end else begin
                    chk("out_sum", out_sum, sbq[0].sum);
                    chk("out_cout", out_cout, sbq[0].cout);
                    chk("out_ovf", out_ovf, sbq[0].ovf);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge with
    // in_valid still high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stuck at %0d", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    logic [W-1:0] bp_a [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF,
                               16'h0000, 16'hAAAA, 16'h8000, 16'h0F0F};
    logic [W-1:0] bp_b [8] = '{16'h4321, 16'h0001, 16'h8000, 16'hFFFF,
                               16'h0001, 16'h5555, 16'h0001, 16'hF0F0};
    logic [7:0]   bp_c = 8'b1011_1000;
    logic [7:0]   bp_s = 8'b1101_0000;

    initial begin
        logic [W-1:0] ovf_sum;
        checks    = 0;
        failures  = 0;
        rdy_mode  = 1'b0;
        rdy_force = 1'b1;
        pat       = 16'b1011_0010_1100_1101;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
`ifdef PIPELINED_CLA_SAT_EN
        ovf_sum = 16'h7FFF;
`else
        ovf_sum = 16'h8000;
`endif

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // latency on an empty pipe
        @(posedge clk); #1;
        send(16'h24D7, 16'h03F8, 1'b0, 1'b0, mk(16'h28CF, 1'b0, 1'b0));
        idle();
        for (int i = 0; i < ST - 1; i++) begin
            @(negedge clk);
            chk("latency_early", out_valid, 0);
        end
        @(negedge clk);
        chk("latency_valid", out_valid, 1);

        // carry, full carry chain, subtract, overflow (back-to-back)
        @(posedge clk); #1;
        send(16'hFDE8, 16'h03F8, 1'b0, 1'b0, mk(16'h01E0, 1'b1, 1'b0));
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(ovf_sum, 1'b0, 1'b1));
        send(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
        idle();
        drain();

        // streaming under pseudo-random backpressure
        rdy_mode = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            send(bp_a[i], bp_b[i], bp_c[7-i], bp_s[7-i],
                 model(bp_a[i], bp_b[i], bp_c[7-i], bp_s[7-i]));
        end
        idle();
        drain();
        rdy_mode = 1'b0;

        // fill while stalled, hold a third beat, then release
        rdy_force = 1'b0;
        @(posedge clk); #1;
        send(16'h0101, 16'h0202, 1'b0, 1'b0, mk(16'h0303, 1'b0, 1'b0));
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0, mk(ovf_sum == 16'h8000 ? 16'h7FFF : 16'h8000, 1'b1, 1'b1));
        fork
            send(16'h0010, 16'h0001, 1'b0, 1'b1, mk(16'h000F, 1'b1, 1'b0));
            begin
                repeat (4) @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        idle();
        drain();

        // reset with two beats in flight
        rdy_force = 1'b0;
        @(posedge clk); #1;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0));
        send(16'h4444, 16'h1111, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_sum", out_sum, 0);
        sbq.delete();
        rdy_force = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
